alu_shift_scheduler: RTL and testbench

//  Shares one cv32e40p_alu instance between NUM_REQ requesters issuing shift/rotate ops.

---
 rtl/alu_shift_sched_pkg.sv | 36 +++
 rtl/alu_shift_scheduler_if.sv | 24 ++
 rtl/alu_shift_scheduler_rr_arbiter.sv | 49 ++++
 rtl/alu_shift_scheduler.sv | 156 +++++++++++++++
 tb/tb_alu_shift_scheduler.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_shift_sched_pkg.sv
// rtl/alu_shift_sched_pkg.sv - shared types and opcode mapping for alu_shift_scheduler
package alu_shift_sched_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2,
    SH_ROR = 2'd3
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } sched_state_e;

  // Local copy of the cv32e40p_pkg::alu_opcode_e shift encodings, bit-identical
  typedef enum logic [6:0] {
    ALU_SRA = 7'b0100100,
    ALU_SRL = 7'b0100101,
    ALU_ROR = 7'b0100110,
    ALU_SLL = 7'b0100111
  } alu_opcode_e;

  function automatic alu_opcode_e to_alu_op(shift_op_e op);
    case (op)
      SH_SRL:  return ALU_SRL;
      SH_SRA:  return ALU_SRA;
      SH_ROR:  return ALU_ROR;
      default: return ALU_SLL;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_scheduler_if.sv
// rtl/alu_shift_scheduler_if.sv - requester request/response bundle for alu_shift_scheduler
interface alu_shift_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ-1:0][1:0]       req_op_i;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_a_i;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_b_i;
  logic [NUM_REQ-1:0]            rsp_valid_o;
  logic [NUM_REQ-1:0]            rsp_ready_i;
  logic [WIDTH-1:0]              rsp_data_o;

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/alu_shift_scheduler_rr_arbiter.sv
// rtl/alu_shift_scheduler_rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer moves past winner on advance
module alu_shift_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  function automatic logic [IDX_W-1:0] wrap(int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_valid_o && req_i[wrap(int'(ptr_q) + i)]) begin
        gnt_valid_o                    = 1'b1;
        gnt_idx_o                      = wrap(int'(ptr_q) + i);
        gnt_o[wrap(int'(ptr_q) + i)]   = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = wrap(int'(gnt_idx_o) + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_shift_scheduler.sv
// rtl/alu_shift_scheduler.sv - shares one ALU between requesters for shift/rotate ops
// Optional ALU_SHIFT_SCHED_STATS_EN adds saturating grant and stall counters.
module alu_shift_scheduler
  import alu_shift_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
) (
  input  logic                clk,
  input  logic                rst,
  alu_shift_scheduler_if.slave bus,
  output logic [6:0]          alu_operator_o,
  output logic [WIDTH-1:0]    alu_operand_a_o,
  output logic [WIDTH-1:0]    alu_operand_b_o,
  output logic                alu_enable_o,
  input  logic [WIDTH-1:0]    alu_result_i,
  input  logic                alu_ready_i
`ifdef ALU_SHIFT_SCHED_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0] stat_grants_o,
  output logic [15:0]              stat_stall_o
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_e     state_q, state_d;
  alu_opcode_e      op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHAMT_W-1:0] b_q, b_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               advance;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;
  logic               enable;
  logic [WIDTH-1:0]   b_sel;
  logic               unused_b_hi;

  alu_shift_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (bus.req_valid_i),
    .advance_i   (advance),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  // Only the low five bits select a shift amount, so larger amounts wrap mod 32
  assign b_sel       = bus.req_b_i[arb_idx];
  assign unused_b_hi = ^b_sel[WIDTH-1:SHAMT_W];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    gnt_d     = gnt_q;
    data_d    = data_q;
    advance   = 1'b0;
    req_ready = '0;
    rsp_valid = '0;
    enable    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          req_ready = arb_gnt;
          advance   = 1'b1;
          op_d      = to_alu_op(shift_op_e'(bus.req_op_i[arb_idx]));
          a_d       = bus.req_a_i[arb_idx];
          b_d       = b_sel[SHAMT_W-1:0];
          gnt_d     = arb_idx;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        enable = 1'b1;
        if (alu_ready_i) begin
          data_d  = alu_result_i;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        if (bus.rsp_ready_i[gnt_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= ALU_SLL;
      a_q     <= '0;
      b_q     <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_data_o  = data_q;
  assign alu_operator_o  = op_q;
  assign alu_operand_a_o = a_q;
  assign alu_operand_b_o = {{(WIDTH-SHAMT_W){1'b0}}, b_q};
  assign alu_enable_o    = enable;

`ifdef ALU_SHIFT_SCHED_STATS_EN
  logic [NUM_REQ-1:0][15:0] grants_q, grants_d;
  logic [15:0]              stall_q, stall_d;

  always_comb begin
    grants_d = grants_q;
    stall_d  = stall_q;
    if (advance && (grants_q[arb_idx] != 16'hFFFF)) begin
      grants_d[arb_idx] = grants_q[arb_idx] + 16'd1;
    end
    if ((state_q == ST_ISSUE) && !alu_ready_i && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q <= '0;
      stall_q  <= '0;
    end else begin
      grants_q <= grants_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_grants_o = grants_q;
  assign stat_stall_o  = stall_q;
`endif

endmodule

// File: tb/tb_alu_shift_scheduler.sv
// tb/tb_alu_shift_scheduler.sv - directed and random checks of alu_shift_scheduler against a behavioural model
module tb_alu_shift_scheduler;

  localparam int N = 2;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_shift_scheduler_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  logic [6:0]   alu_operator;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_enable, alu_ready;
`ifdef ALU_SHIFT_SCHED_STATS_EN
  logic [N-1:0][15:0] stat_grants;
  logic [15:0]        stat_stall;
`endif

  alu_shift_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .alu_operator_o  (alu_operator),
    .alu_operand_a_o (alu_a),
    .alu_operand_b_o (alu_b),
    .alu_enable_o    (alu_enable),
    .alu_result_i    (alu_result),
    .alu_ready_i     (alu_ready)
`ifdef ALU_SHIFT_SCHED_STATS_EN
    ,
    .stat_grants_o   (stat_grants),
    .stat_stall_o    (stat_stall)
`endif
  );

  // Stand-in for the shared ALU: decodes the cv32e40p shift opcodes
  logic [4:0]  alu_sh;
  logic [63:0] alu_rot;
  assign alu_sh  = alu_b[4:0];
  assign alu_rot = {alu_a, alu_a} >> alu_sh;
  always_comb begin
    case (alu_operator)
      7'b0100111: alu_result = alu_a << alu_sh;
      7'b0100101: alu_result = alu_a >> alu_sh;
      7'b0100100: alu_result = $signed(alu_a) >>> alu_sh;
      7'b0100110: alu_result = alu_rot[31:0];
      default:    alu_result = 32'hDEAD_BEEF;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]   p_op [N];
  logic [31:0]  p_a  [N];
  logic [31:0]  p_b  [N];
  logic [N-1:0] pend;
  int           ptr_m;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    int s;
    s = int'(b % 32);
    case (op)
      2'd0:    return a << s;
      2'd1:    return a >> s;
      2'd2:    return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      default: return (s == 0) ? a : ((a >> s) | (a << (32 - s)));
    endcase
  endfunction

  function automatic logic [6:0] opcode_of(logic [1:0] op);
    case (op)
      2'd0:    return 7'b0100111;
      2'd1:    return 7'b0100101;
      2'd2:    return 7'b0100100;
      default: return 7'b0100110;
    endcase
  endfunction

  function automatic int winner();
    for (int i = 0; i < N; i++) begin
      if (pend[(ptr_m + i) % N]) return (ptr_m + i) % N;
    end
    return 0;
  endfunction

  task automatic drive_reqs();
    bus.req_valid_i = pend;
    for (int i = 0; i < N; i++) begin
      bus.req_op_i[i] = p_op[i];
      bus.req_a_i[i]  = p_a[i];
      bus.req_b_i[i]  = p_b[i];
    end
  endtask

  task automatic set_req(int i, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    p_op[i] = op;
    p_a[i]  = a;
    p_b[i]  = b;
    pend[i] = 1'b1;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, " req_ready"}, 32'(bus.req_ready_o), 32'h0);
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid_o), 32'h0);
    check({tag, " rsp_data"},  bus.rsp_data_o, 32'h0);
    check({tag, " enable"},    32'(alu_enable), 32'h0);
    check({tag, " opa"},       alu_a, 32'h0);
    check({tag, " opb"},       alu_b, 32'h0);
    check({tag, " operator"},  32'(alu_operator), 32'h27);
  endtask

  // One full accept/issue/respond transaction with the given ALU stall and response back-pressure
  task automatic run_txn(string tag, int stall, int rdel, bit use_fixed, logic [31:0] fixed);
    int          w;
    logic [31:0] exp, ea, eb;
    logic [6:0]  opc;
    drive_reqs();
    #1;
    w   = winner();
    exp = use_fixed ? fixed : ref_shift(p_op[w], p_a[w], p_b[w]);
    opc = opcode_of(p_op[w]);
    ea  = p_a[w];
    eb  = {27'b0, p_b[w][4:0]};
    check({tag, " idle rsp_valid"}, 32'(bus.rsp_valid_o), 32'h0);
    check({tag, " grant"}, 32'(bus.req_ready_o), 32'(1 << w));
    @(posedge clk); #1;
    pend[w] = 1'b0;
    ptr_m   = (w + 1) % N;
    drive_reqs();
    for (int s = 0; s <= stall; s++) begin
      alu_ready = (s == stall);
      #1;
      check({tag, " issue enable"},    32'(alu_enable), 32'h1);
      check({tag, " issue operator"},  32'(alu_operator), 32'(opc));
      check({tag, " issue opa"},       alu_a, ea);
      check({tag, " issue opb"},       alu_b, eb);
      check({tag, " issue rsp_valid"}, 32'(bus.rsp_valid_o), 32'h0);
      check({tag, " issue req_ready"}, 32'(bus.req_ready_o), 32'h0);
      @(posedge clk); #1;
    end
    alu_ready = 1'b0;
    for (int d = 0; d <= rdel; d++) begin
      bus.rsp_ready_i = (d == rdel) ? N'(1 << w) : ~N'(1 << w);
      #1;
      check({tag, " rsp_valid"},      32'(bus.rsp_valid_o), 32'(1 << w));
      check({tag, " rsp_data"},       bus.rsp_data_o, exp);
      check({tag, " resp req_ready"}, 32'(bus.req_ready_o), 32'h0);
      check({tag, " resp enable"},    32'(alu_enable), 32'h0);
      @(posedge clk); #1;
    end
    bus.rsp_ready_i = '0;
    alu_ready       = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    alu_ready       = 1'b1;
    pend            = '0;
    ptr_m           = 0;
    bus.rsp_ready_i = '0;
    for (int i = 0; i < N; i++) begin
      p_op[i] = 2'd0;
      p_a[i]  = 32'h0;
      p_b[i]  = 32'h0;
    end
    drive_reqs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    set_req(0, 2'd2, 32'h8000_0000, 32'd4);
    run_txn("t1_sra", 0, 0, 1'b1, 32'hF800_0000);

    set_req(1, 2'd3, 32'd5, 32'd1);
    run_txn("t3_ror1", 0, 0, 1'b1, 32'h8000_0002);

    set_req(0, 2'd1, 32'd4, 32'd1);
    set_req(1, 2'd0, 32'd5, 32'd2);
    run_txn("t2_pair_req0", 0, 0, 1'b1, 32'd2);
    set_req(0, 2'd3, 32'd5, 32'd33);
    run_txn("t2_pair_req1", 0, 0, 1'b1, 32'd20);
    run_txn("t3_ror33", 0, 0, 1'b1, 32'h8000_0002);

    set_req(0, 2'd1, 32'hF000_000F, 32'd36);
    set_req(1, 2'd0, 32'h0000_0001, 32'd31);
    run_txn("t4_backpressure", 0, 5, 1'b1, 32'h8000_0000);
    run_txn("t5_alu_stall", 3, 0, 1'b1, 32'h0F00_0000);

    set_req(1, 2'd2, 32'h1234_5678, 32'd8);
    drive_reqs();
    #1;
    check("t6 grant", 32'(bus.req_ready_o), 32'h2);
    @(posedge clk); #1;
    pend      = '0;
    drive_reqs();
    alu_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    alu_ready = 1'b1;
    check_reset_outputs("t6_rst");
    ptr_m = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("t6 no rsp", 32'(bus.rsp_valid_o), 32'h0);
      check("t6 no enable", 32'(alu_enable), 32'h0);
    end

    set_req(0, 2'd0, 32'h0000_00FF, 32'd4);
    set_req(1, 2'd1, 32'h0000_00FF, 32'd4);
    run_txn("t6_ptr_reset", 0, 0, 1'b1, 32'h0000_0FF0);

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          set_req(i, 2'($urandom_range(0, 3)), $urandom, $urandom);
        end
      end
      if (pend == '0) begin
        set_req(int'($urandom_range(0, N - 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
      end
      run_txn("rand", int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
